// File: rtl/processor_pkg.sv
// Shared definitions for processor_core: instruction encodings, memory depth
// and the packing helper for the flat register-file dump.
package processor_pkg;

  localparam int unsigned MEM_WORDS = 512;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // $0 sits in the top word of the dump, $31 in the bottom word.
  function automatic int unsigned reg_msb(input int unsigned n);
    return 1023 - 32 * n;
  endfunction

endpackage

// File: rtl/processor_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, $0 hardwired to zero, and a flat 1024-bit snapshot of all registers.
module processor_regfile
  import processor_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    raddr1_i,
  input  logic [4:0]    raddr2_i,
  output logic [31:0]   rdata1_o,
  output logic [31:0]   rdata2_o,
  input  logic          we_i,
  input  logic [4:0]    waddr_i,
  input  logic [31:0]   wdata_i,
  output logic [1023:0] regs_o
);

  logic [31:0] rf_q [32];

  // NOTE: the register file is architectural state that must clear on reset,
  // unlike the main memory, so every entry gets a reset value here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // rf_q[0] is only ever written by reset, so it reads as zero.
  assign rdata1_o = rf_q[raddr1_i];
  assign rdata2_o = rf_q[raddr2_i];

  for (genvar g = 0; g < 32; g++) begin : g_dump
    assign regs_o[reg_msb(g) -: 32] = rf_q[g];
  end

endmodule

// File: rtl/processor_core.sv
// Single-cycle MIPS-subset core with a unified 512-word memory that is
// preloaded through the load port and then executes one instruction per clock.
module processor_core
  import processor_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   inst,
  input  logic [31:0]   instAddr,
  input  logic          load,
  output logic [1023:0] regs
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] instr, pc4, sext, ea, lw_data;
  logic [31:0] rs_val, rt_val;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic        rf_we, mem_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        unused_bits;

  assign instr   = mem_q[pc_q[10:2]];
  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign sext    = {{16{instr[15]}}, instr[15:0]};
  assign pc4     = pc_q + 32'd4;
  assign ea      = rs_val + sext;
  assign lw_data = mem_q[ea[10:2]];

  // Only word-index bits of the load address select a memory location.
  assign unused_bits = ^{instAddr[31:11], instAddr[1:0]};

  processor_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .regs_o   (regs)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the decode leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_d     = pc4;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = ea;
    mem_we   = 1'b0;
    if (load) begin
      pc_d = '0;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          rf_waddr = rd;
          case (funct)
            FN_ADD: begin rf_we = 1'b1; rf_wdata = rs_val + rt_val; end
            FN_SUB: begin rf_we = 1'b1; rf_wdata = rs_val - rt_val; end
            FN_XOR: begin rf_we = 1'b1; rf_wdata = rs_val ^ rt_val; end
            FN_JR:  pc_d = rs_val;
            default: ;
          endcase
        end
        OP_ADDI: rf_we = 1'b1;
        OP_SUBI: begin rf_we = 1'b1; rf_wdata = rs_val - sext; end
        OP_LW:   begin rf_we = 1'b1; rf_wdata = lw_data; end
        OP_SW:   mem_we = 1'b1;
        OP_BEQ:  if (rs_val == rt_val) pc_d = pc4 + {sext[29:0], 2'b00};
        OP_J:    pc_d = {pc4[31:28], instr[25:0], 2'b00};
        OP_JAL: begin
          pc_d     = {pc4[31:28], instr[25:0], 2'b00};
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = pc4;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  // NOTE: memory has no reset; its contents survive reset by design.
  always_ff @(posedge clk) begin
    if (load)        mem_q[instAddr[10:2]] <= inst;
    else if (mem_we) mem_q[ea[10:2]]       <= rt_val;
  end

endmodule

// File: tb/tb_processor_core.sv
// Scoreboard bench for processor_core: each scenario preloads a program,
// queues per-cycle register expectations and compares them as cycles retire.
module tb_processor_core;

  logic          clk;
  logic          reset;
  logic [31:0]   inst;
  logic [31:0]   inst_addr;
  logic          load;
  logic [1023:0] regs;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  processor_core dut (
    .clk      (clk),
    .reset    (reset),
    .inst     (inst),
    .instAddr (inst_addr),
    .load     (load),
    .regs     (regs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] reg_of(input int n);
    return regs[1023 - 32 * n -: 32];
  endfunction

  task automatic push(input int cyc, input int idx, input logic [31:0] val, input string name);
    sb.push_back('{cyc, idx, val, name});
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    load      = 1'b1;
    inst_addr = addr;
    inst      = data;
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input logic [31:0] words[$]);
    for (int i = 0; i < 16; i++) load_word(32'(i * 4), 32'h0);
    foreach (words[i]) load_word(32'(i * 4), words[i]);
  endtask

  // Async reset pulse between edges, then release into execute mode.
  task automatic start_exec();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    load  = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_compared++;
    if (regs !== '0) begin
      n_mismatched++;
      $display("FAIL reset_regs: got %h want all zero", regs[1023:992]);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_arith();
    load_prog('{32'h20010005, 32'h00211020, 32'h08000000, 32'h20010063});
    push(1, 1, 32'd5,  "arith_addi");
    push(2, 2, 32'd10, "arith_add");
    push(3, 1, 32'd5,  "arith_j_hold1");
    push(3, 2, 32'd10, "arith_j_hold2");
    push(4, 1, 32'd5,  "arith_after_jump");
    push(5, 2, 32'd10, "arith_loop_add");
    start_exec();
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_compared++;
        if (reg_of(e.idx) !== e.val) begin
          n_mismatched++;
          $display("FAIL %s: $%0d got %h want %h", e.name, e.idx, reg_of(e.idx), e.val);
        end
      end
    end
  endtask

  task automatic test_subi_xor();
    load_prog('{32'h20040007, 32'h28030003, 32'h00632026, 32'h00032822});
    push(1, 4, 32'd7,        "addi_r4");
    push(2, 3, 32'hFFFFFFFD, "subi_neg");
    push(3, 4, 32'd0,        "xor_self");
    push(4, 5, 32'd3,        "sub_wrap");
    start_exec();
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_compared++;
        if (reg_of(e.idx) !== e.val) begin
          n_mismatched++;
          $display("FAIL %s: $%0d got %h want %h", e.name, e.idx, reg_of(e.idx), e.val);
        end
      end
    end
  endtask

  task automatic test_memory();
    load_prog('{32'h8C0507FC, 32'hAC0507F8, 32'h8C0607F8, 32'h8C07FFFC});
    load_word(32'h7FC, 32'hDEADBEEF);
    load_word(32'h7F8, 32'h0);
    push(1, 5, 32'hDEADBEEF, "lw_top_word");
    push(2, 6, 32'h0,        "sw_no_regwrite");
    push(3, 6, 32'hDEADBEEF, "lw_after_sw");
    push(4, 7, 32'hDEADBEEF, "lw_addr_wrap");
    start_exec();
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_compared++;
        if (reg_of(e.idx) !== e.val) begin
          n_mismatched++;
          $display("FAIL %s: $%0d got %h want %h", e.name, e.idx, reg_of(e.idx), e.val);
        end
      end
    end
  endtask

  task automatic test_branch();
    load_prog('{32'h10000002, 32'h20010011, 32'h20010022, 32'h20020005,
                32'h10400001, 32'h20030033, 32'h20030044});
    push(2, 2, 32'd5,    "beq_taken_target");
    push(2, 1, 32'd0,    "beq_taken_skip");
    push(4, 3, 32'h33,   "beq_not_taken");
    push(5, 3, 32'h44,   "beq_fallthrough_next");
    start_exec();
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_compared++;
        if (reg_of(e.idx) !== e.val) begin
          n_mismatched++;
          $display("FAIL %s: $%0d got %h want %h", e.name, e.idx, reg_of(e.idx), e.val);
        end
      end
    end
  endtask

  task automatic test_jal_jr();
    load_prog('{32'h0C000003, 32'h20010055, 32'h08000002, 32'h03E00008});
    push(1, 31, 32'd4,  "jal_link");
    push(2, 1,  32'd0,  "jal_target");
    push(3, 1,  32'h55, "jr_return");
    push(5, 1,  32'h55, "j_self_loop");
    push(5, 31, 32'd4,  "jal_link_hold");
    start_exec();
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_compared++;
        if (reg_of(e.idx) !== e.val) begin
          n_mismatched++;
          $display("FAIL %s: $%0d got %h want %h", e.name, e.idx, reg_of(e.idx), e.val);
        end
      end
    end
  endtask

  task automatic test_load_mid();
    load_prog('{32'h20210001, 32'h20420001, 32'h08000000});
    push(1, 1, 32'd1, "incr_r1");
    push(2, 2, 32'd1, "incr_r2");
    push(3, 1, 32'd1, "load_hold_r1");
    push(3, 2, 32'd1, "load_hold_r2");
    push(4, 1, 32'd2, "restart_at_zero");
    push(4, 2, 32'd1, "restart_r2_hold");
    push(5, 2, 32'd2, "restart_second");
    start_exec();
    inst_addr = 32'h100;
    inst      = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      load = (c == 3);
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_compared++;
        if (reg_of(e.idx) !== e.val) begin
          n_mismatched++;
          $display("FAIL %s: $%0d got %h want %h", e.name, e.idx, reg_of(e.idx), e.val);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_zero_and_reset();
    load_prog('{32'h20000007, 32'h20010005, 32'h08000000});
    push(1, 0, 32'd0, "r0_discard");
    push(2, 1, 32'd5, "pre_reset_r1");
    push(3, 1, 32'd0, "post_reset_from_zero");
    push(3, 0, 32'd0, "post_reset_r0");
    push(4, 1, 32'd5, "post_reset_mem_kept");
    start_exec();
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) begin
        reset = 1'b1;
        #1;
        n_compared++;
        if (regs !== '0) begin
          n_mismatched++;
          $display("FAIL async_reset: $1 got %h want all regs zero", reg_of(1));
        end
        reset = 1'b0;
      end
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        n_compared++;
        if (reg_of(e.idx) !== e.val) begin
          n_mismatched++;
          $display("FAIL %s: $%0d got %h want %h", e.name, e.idx, reg_of(e.idx), e.val);
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    load      = 1'b1;
    inst      = '0;
    inst_addr = '0;
    test_reset();
    test_arith();
    test_subi_xor();
    test_memory();
    test_branch();
    test_jal_jr();
    test_load_mid();
    test_zero_and_reset();
    if (sb.size() != 0) begin
      n_mismatched += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
